// File: rtl/neuron_mac_if.sv
// Handshake, weight-write and result signals of one sequential neuron.
// Master drives the request side; slave is the neuron itself.
interface neuron_mac_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N_INPUTS   = 4
);
    localparam int AW = $clog2(N_INPUTS + 1);

    logic                           en;
    logic                           start;
    logic [1:0]                     act_mode;
    logic [N_INPUTS*DATA_WIDTH-1:0] x;
    logic                           w_we;
    logic [AW-1:0]                  w_addr;
    logic signed [DATA_WIDTH-1:0]   w_data;
    logic                           busy;
    logic                           done;
    logic signed [DATA_WIDTH-1:0]   y;

    modport master (
        output en, start, act_mode, x, w_we, w_addr, w_data,
        input  busy, done, y
    );

    modport slave (
        input  en, start, act_mode, x, w_we, w_addr, w_data,
        output busy, done, y
    );
endinterface

// File: rtl/neuron_mac_seq.sv
// Sequential fixed-point neuron: one shared multiplier, one input per cycle,
// runtime-writable weights/bias, selectable activation and output saturation.
module neuron_mac_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 4,
    parameter int N_INPUTS   = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N_INPUTS) + 1
) (
    input logic         clk,
    input logic         rst,
    neuron_mac_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = 2*DATA_WIDTH;
    localparam int AW = $clog2(N_INPUTS + 1);
    localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [AW-1:0] BIAS_ADDR = AW'(N_INPUTS);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_INPUTS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2**(DW-1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2**(DW-1)));

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_ACT, S_DONE} state_t;

    state_t state, state_nxt;

    logic signed [DW-1:0]        w_r  [N_INPUTS];
    logic signed [DW-1:0]        wk   [N_INPUTS];
    logic signed [DW-1:0]        xr   [N_INPUTS];
    logic signed [DW-1:0]        bias_r;
    logic [1:0]                  mode_r;
    logic signed [ACC_WIDTH-1:0] acc;
    logic [IW-1:0]               idx;
    logic signed [DW-1:0]        y_r;

    logic signed [PW-1:0]        prod, prod_sh;
    logic signed [ACC_WIDTH-1:0] prod_ext, v_act;
    logic signed [DW-1:0]        y_nxt;

    logic idle_go;
    assign idle_go = bus.en && (state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.en) begin
            case (state)
                S_IDLE:  if (bus.start) state_nxt = S_LOAD;
                S_LOAD:  state_nxt = S_MAC;
                S_MAC:   if (idx == LAST_IDX) state_nxt = S_ACT;
                S_ACT:   state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Live weights take writes only while idle; the run works from a snapshot
    // taken at start, so a write coinciding with start does not affect it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_INPUTS; i++) w_r[i] <= '0;
            bias_r <= '0;
        end else if (idle_go && bus.w_we) begin
            if (bus.w_addr == BIAS_ADDR) bias_r <= bus.w_data;
            for (int i = 0; i < N_INPUTS; i++)
                if (bus.w_addr == AW'(i)) w_r[i] <= bus.w_data;
        end
    end

    // Full-width product, floor shift, sign-extended into the accumulator.
    assign prod     = xr[idx] * wk[idx];
    assign prod_sh  = prod >>> FRAC_BITS;
    assign prod_ext = {{(ACC_WIDTH-PW){prod_sh[PW-1]}}, prod_sh};

    always_comb begin
        v_act = acc;
        case (mode_r)
            2'd0:    v_act = acc;
            2'd2:    v_act = acc[ACC_WIDTH-1] ? (acc >>> 3) : acc;
            default: v_act = acc[ACC_WIDTH-1] ? '0 : acc;
        endcase
        y_nxt = v_act[DW-1:0];
        if (v_act > SAT_MAX)      y_nxt = SAT_MAX[DW-1:0];
        else if (v_act < SAT_MIN) y_nxt = SAT_MIN[DW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            idx    <= '0;
            y_r    <= '0;
            mode_r <= '0;
            for (int i = 0; i < N_INPUTS; i++) begin
                xr[i] <= '0;
                wk[i] <= '0;
            end
        end else if (bus.en) begin
            case (state)
                S_IDLE: if (bus.start) begin
                    for (int i = 0; i < N_INPUTS; i++) begin
                        xr[i] <= bus.x[i*DW +: DW];
                        wk[i] <= w_r[i];
                    end
                    mode_r <= bus.act_mode;
                    acc    <= {{(ACC_WIDTH-DW){bias_r[DW-1]}}, bias_r};
                    idx    <= '0;
                end
                S_MAC: begin
                    acc <= acc + prod_ext;
                    idx <= idx + 1'b1;
                end
                S_ACT:   y_r <= y_nxt;
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);
    assign bus.y    = y_r;
endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Parametrised sequential neuron for the fixed-point network datapath. It computes one weighted sum, y = act(bias + Σ (x[i]·w[i]) >>> FRAC_BITS), using a single time-shared multiplier, one input per cycle. Weights and bias are runtime-writable registers, not synthesis constants. It adds a start/done handshake, a selectable activation function and output saturation, and it drops into layer wrappers in place of fixed-weight, fixed-fan-in neurons.

## Interface
- DATA_WIDTH, 8, signed width of inputs, weights, bias and y (Q format with FRAC_BITS fractional bits)
- FRAC_BITS, 4, fractional bits; each product is arithmetically shifted right by this amount
- N_INPUTS, 4, fan-in; must be ≥1
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(N_INPUTS)+1, signed accumulator width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  clock enable; when low, all state, accumulator, index and outputs hold
- start  in  1  request one evaluation; sampled only in IDLE with en=1
- act_mode  in  2  activation select: 0 = linear, 1 = ReLU, 2 = leaky ReLU (negative >>>3), 3 = ReLU; latched at start
- x  in  N_INPUTS*DATA_WIDTH  packed signed inputs, x[i] = bits [i*DW +: DW]; latched at start
- w_we  in  1  weight/bias write strobe
- w_addr  in  $clog2(N_INPUTS+1)  0..N_INPUTS-1 selects w[i]; N_INPUTS selects bias
- w_data  in  DATA_WIDTH  signed write data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when y is updated
- y  out  DATA_WIDTH  signed result; holds until the next done

## Operation
- States: IDLE, LOAD, MAC, ACT, DONE. Every transition requires en=1.
- IDLE: start=1 moves to LOAD. Latches x into internal registers, act_mode into mode_r, and sets acc ← sign-extended bias and idx ← 0.
- LOAD (1 cycle): moves to MAC.
- MAC (N_INPUTS cycles): acc ← acc + sext((xr[idx]·w[idx]) >>> FRAC_BITS) and idx ← idx+1. Leaves for ACT after idx = N_INPUTS-1.
- Product: full 2·DATA_WIDTH signed. The shift is arithmetic and rounds toward −∞; for example, −1 >>> 4 = −1.
- Products are not truncated before accumulation. The accumulator never wraps within its ACC_WIDTH.
- ACT (1 cycle): v = acc if mode_r=0; max(acc,0) if mode_r∈{1,3}; acc≥0 ? acc : acc>>>3 if mode_r=2.
  - v is saturated to [−2^(DW−1), 2^(DW−1)−1] and registered into y. done is asserted. State moves to DONE.
- DONE (1 cycle): done=1, then IDLE.
- Weight/bias writes are applied only when w_we=1, en=1 and state=IDLE. Writes in other states are dropped.
  - If a write and start occur in the same cycle, the write applies and the run uses the old value.
- start is ignored while busy (no queueing).
- Reset mid-operation aborts the run. State returns to IDLE; acc, idx, y, done and busy clear. All weights and the bias reset to 0.

## Timing
- Reset values: y=0, done=0, busy=0, state=IDLE, w[*]=0, bias=0.
- With start sampled at edge t:
  - busy rises after t.
  - done is high for exactly one cycle, starting after edge t+N_INPUTS+2 (N=4: 6 edges).
  - y changes at that same edge.
- busy falls at the edge after done. The next start is accepted in the following cycle. Back-to-back throughput is one result per N_INPUTS+4 cycles.
- x, act_mode and weights may change freely after the start edge without affecting the run.
- en low for k cycles stretches latency by exactly k. done stays high for the full stall if the stall lands in DONE.

## Test plan
- Nominal ReLU: N=4, DW=8, FRAC=4; w = {4, −8, −4, 4}, bias=6, x = {16,16,16,16}, mode 1 -> products >>>4 = {4,−8,−4,4}, y=2, done 6 edges after start.
- Negative sum: same weights; x = {0,32,0,0} -> mode 1 gives y=0; mode 0 gives y=−10; mode 2 gives y=−2.
- Saturation: all w=127, bias=127, x all 127, mode 0 -> acc=4159, y=127. With all w=−128, x all 127, bias=0 -> y=−128.
- Rounding: w0=1, others 0, bias=0, x0=−1, mode 0 -> y=−1.
- Handshake/stall: start during busy is ignored. A weight write during MAC is dropped (rerun gives the same y). en low 3 cycles mid-MAC -> done arrives 9 edges after start.
- Reset mid-MAC: assert rst at cycle 3 -> busy=0, y=0, weights 0. A fresh run with no writes -> y=0.
